mine_place_ctrl: RTL and testbench
==================================

Name: mine_place_ctrl

Overview:
Controller that sequences the LCG mine-placement datapath for the 5x5 board: X[n+1] = (a*X[n] + c) mod 25.
- Produces one candidate cell per cycle and rejects duplicates and the protected first-click cell.
- Falls back to a linear probe when the LCG stalls, and counts placements until the requested mine count is reached.
- Sits between the game FSM (issues start and first-click cell) and the board state register (consumes out_mines).

Parameters:
N_CELLS, 25, board cells (5x5); index width 5.
MAX_MINES, 24, clamp on requested mine count (one cell always safe).
MAX_TRIES, 8, consecutive LCG rejects before switching to probe mode.

Ports:
in_clka  input  1  clock; all logic on rising edge.
in_reset  input  1  synchronous, active-high reset.
in_start  input  1  one-cycle start request; sampled only in IDLE or DONE.
in_mult  input  5  LCG multiplier a; latched on accepted start.
in_increment  input  5  LCG increment c; latched on accepted start.
in_seed  input  5  initial X; latched as in_seed mod 25.
in_mines_num  input  5  requested mines; latched as min(in_mines_num, MAX_MINES).
in_safe_cell  input  5  first-click cell never mined; a value >=25 means no exclusion.
out_busy  output  1  high in GEN/PROBE.
out_place_done  output  1  level, high in DONE until next accepted start or reset.
out_mine_count  output  5  mines placed so far.
out_mines  output  25  bit i = cell i mined; stable while out_place_done=1.

Behaviour:
- Reset (in_reset=1 at a clock edge):
  - state=IDLE; all outputs 0; internal x, tries, probe index 0.
  - Reset has priority over everything, including mid-GEN or mid-PROBE.
- IDLE/DONE with in_start=1:
  - Latch a, c, target, safe cell; x <= in_seed mod 25.
  - Clear out_mines, count, tries; out_place_done <= 0.
  - If target==0 go to DONE, else go to GEN.
  - in_start while busy is ignored.
- GEN, one candidate per cycle:
  - cand = (a*x + c) mod 25, computed at 10-bit width (max 31*24+31=775); x <= cand.
  - Accept when out_mines[cand]==0 and cand!=safe:
    - Set the bit, count+1, tries <= 0.
    - If count+1==target go to DONE.
  - Reject:
    - If tries==MAX_TRIES-1, go to PROBE with pidx <= (cand+1) mod 25 and tries <= 0.
    - Otherwise tries+1.
- PROBE, one cell per cycle:
  - If out_mines[pidx]==0 and pidx!=safe: place the mine, count+1, go to DONE if target is reached, else go to GEN.
  - Otherwise pidx <= pidx+1, wrapping 24->0.
  - Termination is guaranteed because target<=24 leaves a free non-safe cell.
- Latency:
  - Start accepted at edge T gives the first GEN evaluation at T+1.
  - out_place_done is high the cycle after the final placement.
  - Worst case per mine is MAX_TRIES+25 cycles.
- out_mines updates only on placement edges; bit count always equals out_mine_count.
- Degenerate LCG inputs (a=0, c=0, short cycles) need no special case; the probe fallback covers them.

Decomposition:
- Package mine_pkg: N_CELLS, MAX_MINES, MAX_TRIES, CELL_W=5, state enum {IDLE, GEN, PROBE, DONE}.
- Sub-module lcg_mod25: purely combinational; inputs a, c, x; output (a*x+c) mod 25.
- Controller FSM, counters and mine register live in mine_place_ctrl.

Test Plan:
- a=1, c=1, seed=0, safe=0, mines=3; start at T -> out_mines=25'h000000E, busy T+1..T+3, out_place_done=1 at T+4, count=3.
- a=0, c=5, seed=0, safe=5, mines=2 -> 8 rejects, PROBE places cell 6, 8 more rejects, PROBE skips 6 and places 7; out_mines=25'h00000C0, done 20 cycles after start.
- mines=30, safe=12, a=7, c=3 -> target clamped to 24; out_mines=25'h1FFEFFF, bit 12 clear, count=24.
- mines=0 -> out_place_done=1 the cycle after start, out_mines=0, busy never asserted.
- a=0, c=24, safe=24, mines=1 -> probe wraps 24->0; out_mines=25'h0000001.
- Mid-run cases:
  - in_reset during GEN -> next cycle all outputs 0, state IDLE.
  - in_start pulses while busy -> ignored.
  - in_start in DONE -> restart clears out_mines and done.

Source files
------------

// File: rtl/mine_pkg.sv
// Shared constants, state encoding and small helpers for the LCG mine placer
// on a 5x5 board.
package mine_pkg;

  localparam int N_CELLS   = 25;
  localparam int MAX_MINES = 24;
  localparam int MAX_TRIES = 8;
  localparam int CELL_W    = 5;
  localparam int TRY_W     = $clog2(MAX_TRIES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    PROBE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A 5-bit value is at most 31, so one conditional subtract is enough.
  function automatic logic [CELL_W-1:0] mod_cells(input logic [CELL_W-1:0] v);
    return (v >= CELL_W'(N_CELLS)) ? v - CELL_W'(N_CELLS) : v;
  endfunction

  function automatic logic [CELL_W-1:0] clamp_mines(input logic [CELL_W-1:0] v);
    return (v > CELL_W'(MAX_MINES)) ? CELL_W'(MAX_MINES) : v;
  endfunction

  function automatic logic [CELL_W-1:0] next_cell(input logic [CELL_W-1:0] v);
    return (v == CELL_W'(N_CELLS - 1)) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/lcg_mod25.sv
// One step of the board LCG: y = (a*x + c) mod 25, evaluated combinationally.
module lcg_mod25
  import mine_pkg::*;
(
  input  logic [CELL_W-1:0] a,
  input  logic [CELL_W-1:0] c,
  input  logic [CELL_W-1:0] x,
  output logic [CELL_W-1:0] y
);

  // 31*31+31 fits in 10 bits, so the sum never wraps before the modulo.
  logic [9:0] full;
  logic [9:0] rem;

  assign full = 10'(a) * 10'(x) + 10'(c);
  assign rem  = full % 10'(N_CELLS);
  assign y    = rem[CELL_W-1:0];

endmodule

// File: rtl/mine_place_ctrl.sv
// Sequences the LCG mine placement: one candidate per cycle, duplicate and
// safe-cell rejection, linear probe fallback after repeated rejects.
module mine_place_ctrl
  import mine_pkg::*;
(
  input  logic                in_clka,
  input  logic                in_reset,
  input  logic                in_start,
  input  logic [CELL_W-1:0]   in_mult,
  input  logic [CELL_W-1:0]   in_increment,
  input  logic [CELL_W-1:0]   in_seed,
  input  logic [CELL_W-1:0]   in_mines_num,
  input  logic [CELL_W-1:0]   in_safe_cell,
  output logic                out_busy,
  output logic                out_place_done,
  output logic [CELL_W-1:0]   out_mine_count,
  output logic [N_CELLS-1:0]  out_mines
);

  state_t              state_q, state_d;
  logic [CELL_W-1:0]   a_q, a_d;
  logic [CELL_W-1:0]   c_q, c_d;
  logic [CELL_W-1:0]   target_q, target_d;
  logic [CELL_W-1:0]   safe_q, safe_d;
  logic [CELL_W-1:0]   x_q, x_d;
  logic [CELL_W-1:0]   pidx_q, pidx_d;
  logic [TRY_W-1:0]    tries_q, tries_d;
  logic [CELL_W-1:0]   count_q, count_d;
  logic [N_CELLS-1:0]  mines_q, mines_d;
  logic [CELL_W-1:0]   cand;
  logic [CELL_W-1:0]   count_inc;
  logic [CELL_W-1:0]   start_target;

  lcg_mod25 u_lcg (
    .a (a_q),
    .c (c_q),
    .x (x_q),
    .y (cand)
  );

  assign count_inc    = count_q + 1'b1;
  assign start_target = clamp_mines(in_mines_num);

  always_comb begin
    // NOTE: every *_d defaults to its register so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    c_d      = c_q;
    target_d = target_q;
    safe_d   = safe_q;
    x_d      = x_q;
    pidx_d   = pidx_q;
    tries_d  = tries_q;
    count_d  = count_q;
    mines_d  = mines_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (in_start) begin
          a_d      = in_mult;
          c_d      = in_increment;
          target_d = start_target;
          safe_d   = in_safe_cell;
          x_d      = mod_cells(in_seed);
          tries_d  = '0;
          count_d  = '0;
          mines_d  = '0;
          state_d  = (start_target == '0) ? DONE : GEN;
        end
      end

      GEN: begin
        x_d = cand;
        if (!mines_q[cand] && cand != safe_q) begin
          mines_d[cand] = 1'b1;
          count_d       = count_inc;
          tries_d       = '0;
          if (count_inc == target_q) state_d = DONE;
        end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
          // The LCG looks stuck; hand over to a linear sweep from the next cell.
          state_d = PROBE;
          pidx_d  = next_cell(cand);
          tries_d = '0;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end

      PROBE: begin
        if (!mines_q[pidx_q] && pidx_q != safe_q) begin
          mines_d[pidx_q] = 1'b1;
          count_d         = count_inc;
          state_d         = (count_inc == target_q) ? DONE : GEN;
        end else begin
          pidx_d = next_cell(pidx_q);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge in_clka) begin
    if (in_reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      c_q      <= '0;
      target_q <= '0;
      safe_q   <= '0;
      x_q      <= '0;
      pidx_q   <= '0;
      tries_q  <= '0;
      count_q  <= '0;
      mines_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      c_q      <= c_d;
      target_q <= target_d;
      safe_q   <= safe_d;
      x_q      <= x_d;
      pidx_q   <= pidx_d;
      tries_q  <= tries_d;
      count_q  <= count_d;
      mines_q  <= mines_d;
    end
  end

  assign out_busy       = (state_q == GEN) || (state_q == PROBE);
  assign out_place_done = (state_q == DONE);
  assign out_mine_count = count_q;
  assign out_mines      = mines_q;

endmodule

// File: tb/tb_mine_place_ctrl.sv
// Directed bench for mine_place_ctrl with hand-computed placement results.
module tb_mine_place_ctrl;

  logic        clk = 1'b0;
  logic        in_reset;
  logic        in_start;
  logic [4:0]  in_mult;
  logic [4:0]  in_increment;
  logic [4:0]  in_seed;
  logic [4:0]  in_mines_num;
  logic [4:0]  in_safe_cell;
  logic        out_busy;
  logic        out_place_done;
  logic [4:0]  out_mine_count;
  logic [24:0] out_mines;

  int checks = 0;
  int passed = 0;
  int n;

  mine_place_ctrl dut (
    .in_clka        (clk),
    .in_reset       (in_reset),
    .in_start       (in_start),
    .in_mult        (in_mult),
    .in_increment   (in_increment),
    .in_seed        (in_seed),
    .in_mines_num   (in_mines_num),
    .in_safe_cell   (in_safe_cell),
    .out_busy       (out_busy),
    .out_place_done (out_place_done),
    .out_mine_count (out_mine_count),
    .out_mines      (out_mines)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic start(input logic [4:0] a, input logic [4:0] c, input logic [4:0] seed,
                       input logic [4:0] mines, input logic [4:0] safe);
    in_mult      = a;
    in_increment = c;
    in_seed      = seed;
    in_mines_num = mines;
    in_safe_cell = safe;
    in_start     = 1'b1;
    tick();
    in_start     = 1'b0;
  endtask

  // Counts cycles until done; an expired bound shows up as a done=0 check.
  task automatic wait_done(input int max_cycles, input string tag, output int cycles);
    cycles = 0;
    while (!out_place_done && cycles < max_cycles) begin
      tick();
      cycles++;
    end
    check({tag, "_done_in_bound"}, {31'b0, out_place_done}, 32'd1);
  endtask

  initial begin
    in_reset = 1'b1;
    in_start = 1'b0;
    in_mult = '0; in_increment = '0; in_seed = '0; in_mines_num = '0; in_safe_cell = '0;
    tick();
    tick();
    check("rst_busy",  {31'b0, out_busy},       32'd0);
    check("rst_done",  {31'b0, out_place_done}, 32'd0);
    check("rst_count", {27'b0, out_mine_count}, 32'd0);
    check("rst_mines", {7'b0, out_mines},       32'd0);
    in_reset = 1'b0;
    tick();

    // a=1 c=1 seed=0 safe=0 mines=3: cells 1,2,3 on consecutive cycles.
    start(5'd1, 5'd1, 5'd0, 5'd3, 5'd0);
    check("t1_busy0", {31'b0, out_busy}, 32'd1);
    tick();
    check("t1_busy1", {31'b0, out_busy}, 32'd1);
    check("t1_cnt1",  {27'b0, out_mine_count}, 32'd1);
    tick();
    check("t1_busy2", {31'b0, out_busy}, 32'd1);
    tick();
    check("t1_done",  {31'b0, out_place_done}, 32'd1);
    check("t1_busyx", {31'b0, out_busy}, 32'd0);
    check("t1_mines", {7'b0, out_mines}, 32'h000000E);
    check("t1_count", {27'b0, out_mine_count}, 32'd3);

    // Restart from DONE; seed 27 reduces to 2, so the single mine lands on 3.
    start(5'd1, 5'd1, 5'd27, 5'd1, 5'd31);
    check("rs_done_clr",  {31'b0, out_place_done}, 32'd0);
    check("rs_mines_clr", {7'b0, out_mines}, 32'd0);
    check("rs_count_clr", {27'b0, out_mine_count}, 32'd0);
    check("rs_busy",      {31'b0, out_busy}, 32'd1);
    tick();
    check("seed_done",  {31'b0, out_place_done}, 32'd1);
    check("seed_mines", {7'b0, out_mines}, 32'h0000008);

    // a=0 c=5 safe=5: LCG stalls on the safe cell, probe places 6 then 7.
    start(5'd0, 5'd5, 5'd0, 5'd2, 5'd5);
    wait_done(100, "t2", n);
    check("t2_latency", n, 32'd19);
    check("t2_mines",   {7'b0, out_mines}, 32'h00000C0);
    check("t2_count",   {27'b0, out_mine_count}, 32'd2);

    // Zero mines: done straight away, never busy.
    start(5'd3, 5'd4, 5'd1, 5'd0, 5'd2);
    check("t4_done",  {31'b0, out_place_done}, 32'd1);
    check("t4_busy",  {31'b0, out_busy}, 32'd0);
    check("t4_mines", {7'b0, out_mines}, 32'd0);
    tick();
    check("t4_busy2", {31'b0, out_busy}, 32'd0);

    // a=0 c=24 safe=24: probe starts past the last cell and wraps to 0.
    start(5'd0, 5'd24, 5'd0, 5'd1, 5'd24);
    wait_done(100, "t5", n);
    check("t5_latency", n, 32'd9);
    check("t5_mines",   {7'b0, out_mines}, 32'h0000001);

    // Request 30 mines: clamped to 24, every cell but the safe one filled.
    start(5'd7, 5'd3, 5'd0, 5'd30, 5'd12);
    wait_done(2000, "t3", n);
    check("t3_mines", {7'b0, out_mines}, 32'h1FFEFFF);
    check("t3_bit12", {31'b0, out_mines[12]}, 32'd0);
    check("t3_count", {27'b0, out_mine_count}, 32'd24);

    // A start pulse mid-run must not disturb the stalled-LCG run.
    start(5'd0, 5'd5, 5'd0, 5'd2, 5'd5);
    tick(); tick(); tick();
    in_mult = 5'd1; in_increment = 5'd1; in_mines_num = 5'd3; in_safe_cell = 5'd0;
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    wait_done(100, "ign", n);
    check("ign_latency", n, 32'd15);
    check("ign_mines",   {7'b0, out_mines}, 32'h00000C0);
    check("ign_count",   {27'b0, out_mine_count}, 32'd2);

    // Reset mid-GEN returns everything to zero on the next cycle.
    start(5'd7, 5'd3, 5'd0, 5'd20, 5'd12);
    tick(); tick(); tick();
    check("mr_busy_pre", {31'b0, out_busy}, 32'd1);
    in_reset = 1'b1;
    tick();
    in_reset = 1'b0;
    check("mr_busy",  {31'b0, out_busy}, 32'd0);
    check("mr_done",  {31'b0, out_place_done}, 32'd0);
    check("mr_count", {27'b0, out_mine_count}, 32'd0);
    check("mr_mines", {7'b0, out_mines}, 32'd0);
    tick();
    check("mr_idle",  {31'b0, out_busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
